// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
//   Stall/flush sequencer for the 5-stage pipeline. It drives the PC and
//   pipeline-register enables and flushes. Three hazard sources are resolved,
//   highest priority first:
//     1. a data-memory access that is not yet ready (freeze),
//     2. a taken branch resolved in EX (flush the two younger stages),
//     3. a load-use dependency (insert one bubble into EX).
//   A bounded memory-wait FSM latches a sticky error if memory never answers.
//   A saturating counter records every cycle in which the PC is held.
//
// Ports
//   clk, reset               clock (rising edge), async active-high reset
//   ifid_rs_i/ifid_rt_i      source fields of the IF/ID instruction
//   ifid_uses_rt_i           IF/ID instruction reads rt
//   idex_mem_rd_i/idex_rt_i  ID/EX load and its destination register
//   ex_branch_taken_i        branch/jump resolved taken in EX this cycle
//   exmem_mem_rd_i/_wr_i     EX/MEM instruction accesses data memory
//   dmem_ready_i             data memory completes the access this cycle
//   dmem_req_o               data memory request
//   pc_en_o, *_en_o          PC and pipeline-register enables
//   *_flush_o                load a bubble instead of the stage input
//   mem_err_o                sticky memory timeout flag
//   stall_cycles_o           saturating count of cycles with pc_en_o=0
module pipeline_hazard_ctrl #(
  parameter int WAIT_LIMIT = 16,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       ifid_rs_i,
  input  logic [4:0]       ifid_rt_i,
  input  logic             ifid_uses_rt_i,
  input  logic             idex_mem_rd_i,
  input  logic [4:0]       idex_rt_i,
  input  logic             ex_branch_taken_i,
  input  logic             exmem_mem_rd_i,
  input  logic             exmem_mem_wr_i,
  input  logic             dmem_ready_i,
  output logic             dmem_req_o,
  output logic             pc_en_o,
  output logic             if_id_en_o,
  output logic             id_ex_en_o,
  output logic             ex_mem_en_o,
  output logic             mem_wb_en_o,
  output logic             if_id_flush_o,
  output logic             id_ex_flush_o,
  output logic             mem_wb_flush_o,
  output logic             mem_err_o,
  output logic [CNT_W-1:0] stall_cycles_o
);

  localparam int WW = $clog2(WAIT_LIMIT);

  typedef enum logic [1:0] {RUN, MEM_WAIT, ERROR} state_t;

  state_t           state_q, state_d;
  logic [WW-1:0]    wait_q, wait_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] stall_q, stall_d;

  logic mem_acc, load_use, freeze, advance, req;

  assign mem_acc  = exmem_mem_rd_i | exmem_mem_wr_i;
  // r0 is hardwired zero, so a load "into" r0 never creates a dependency.
  assign load_use = idex_mem_rd_i && (idex_rt_i != 5'd0) &&
                    ((idex_rt_i == ifid_rs_i) ||
                     (ifid_uses_rt_i && (idex_rt_i == ifid_rt_i)));

  // Next state: decide whether the pipeline freezes or advances this cycle.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    err_d   = err_q;
    freeze  = 1'b0;
    advance = 1'b0;
    req     = 1'b0;
    case (state_q)
      RUN: begin
        req = mem_acc;
        if (mem_acc && !dmem_ready_i) begin
          freeze  = 1'b1;
          state_d = MEM_WAIT;
          wait_d  = '0;
        end else begin
          advance = 1'b1;
        end
      end
      MEM_WAIT: begin
        req = 1'b1;
        if (dmem_ready_i) begin
          advance = 1'b1;
          state_d = RUN;
        end else begin
          freeze = 1'b1;
          if (wait_q == WW'(WAIT_LIMIT - 1)) begin
            state_d = ERROR;
            err_d   = 1'b1;
          end else begin
            wait_d = wait_q + 1'b1;
          end
        end
      end
      ERROR:   ;
      default: state_d = RUN;
    endcase
  end

  // Enables and flushes. During a freeze only MEM/WB clocks, and it clocks a
  // bubble so the instruction in WB does not write back twice.
  always_comb begin
    dmem_req_o     = 1'b0;
    pc_en_o        = 1'b0;
    if_id_en_o     = 1'b0;
    id_ex_en_o     = 1'b0;
    ex_mem_en_o    = 1'b0;
    mem_wb_en_o    = 1'b0;
    if_id_flush_o  = 1'b0;
    id_ex_flush_o  = 1'b0;
    mem_wb_flush_o = 1'b0;
    if (!reset) begin
      dmem_req_o = req;
      if (freeze) begin
        mem_wb_en_o    = 1'b1;
        mem_wb_flush_o = 1'b1;
      end else if (advance) begin
        pc_en_o     = 1'b1;
        if_id_en_o  = 1'b1;
        id_ex_en_o  = 1'b1;
        ex_mem_en_o = 1'b1;
        mem_wb_en_o = 1'b1;
        // A taken branch squashes the load consumer, so its hazard is moot.
        if (ex_branch_taken_i) begin
          if_id_flush_o = 1'b1;
          id_ex_flush_o = 1'b1;
        end else if (load_use) begin
          pc_en_o       = 1'b0;
          if_id_en_o    = 1'b0;
          id_ex_flush_o = 1'b1;
        end
      end
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (!pc_en_o && (stall_q != '1)) stall_d = stall_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      wait_q  <= '0;
      err_q   <= 1'b0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
      stall_q <= stall_d;
    end
  end

  assign mem_err_o      = err_q;
  assign stall_cycles_o = stall_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] ifid_rs, ifid_rt, idex_rt;
  logic       ifid_uses_rt, idex_mem_rd, ex_branch_taken;
  logic       exmem_mem_rd, exmem_mem_wr, dmem_ready;

  logic        dmem_req, pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic        if_id_flush, id_ex_flush, mem_wb_flush, mem_err;
  logic [15:0] stall_cycles;

  logic        s_dmem_req, s_pc_en, s_if_id_en, s_id_ex_en, s_ex_mem_en, s_mem_wb_en;
  logic        s_if_id_flush, s_id_ex_flush, s_mem_wb_flush, s_mem_err;
  logic [3:0]  s_stall_cycles;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl dut (
    .clk(clk), .reset(reset),
    .ifid_rs_i(ifid_rs), .ifid_rt_i(ifid_rt), .ifid_uses_rt_i(ifid_uses_rt),
    .idex_mem_rd_i(idex_mem_rd), .idex_rt_i(idex_rt),
    .ex_branch_taken_i(ex_branch_taken),
    .exmem_mem_rd_i(exmem_mem_rd), .exmem_mem_wr_i(exmem_mem_wr),
    .dmem_ready_i(dmem_ready), .dmem_req_o(dmem_req),
    .pc_en_o(pc_en), .if_id_en_o(if_id_en), .id_ex_en_o(id_ex_en),
    .ex_mem_en_o(ex_mem_en), .mem_wb_en_o(mem_wb_en),
    .if_id_flush_o(if_id_flush), .id_ex_flush_o(id_ex_flush),
    .mem_wb_flush_o(mem_wb_flush), .mem_err_o(mem_err),
    .stall_cycles_o(stall_cycles)
  );

  // Narrow-counter instance for the saturation check; shares all stimulus.
  pipeline_hazard_ctrl #(.WAIT_LIMIT(16), .CNT_W(4)) dut_s (
    .clk(clk), .reset(reset),
    .ifid_rs_i(ifid_rs), .ifid_rt_i(ifid_rt), .ifid_uses_rt_i(ifid_uses_rt),
    .idex_mem_rd_i(idex_mem_rd), .idex_rt_i(idex_rt),
    .ex_branch_taken_i(ex_branch_taken),
    .exmem_mem_rd_i(exmem_mem_rd), .exmem_mem_wr_i(exmem_mem_wr),
    .dmem_ready_i(dmem_ready), .dmem_req_o(s_dmem_req),
    .pc_en_o(s_pc_en), .if_id_en_o(s_if_id_en), .id_ex_en_o(s_id_ex_en),
    .ex_mem_en_o(s_ex_mem_en), .mem_wb_en_o(s_mem_wb_en),
    .if_id_flush_o(s_if_id_flush), .id_ex_flush_o(s_id_ex_flush),
    .mem_wb_flush_o(s_mem_wb_flush), .mem_err_o(s_mem_err),
    .stall_cycles_o(s_stall_cycles)
  );

  // {pc, if_id, id_ex, ex_mem, mem_wb enables, if_id, id_ex, mem_wb flushes, dmem_req}
  logic [8:0] ctl;
  assign ctl = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                if_id_flush, id_ex_flush, mem_wb_flush, dmem_req};

  localparam logic [8:0] C_ZERO = 9'b00000_000_0;
  localparam logic [8:0] C_DEF  = 9'b11111_000_0;
  localparam logic [8:0] C_DEFR = 9'b11111_000_1;
  localparam logic [8:0] C_FRZ  = 9'b00001_001_1;
  localparam logic [8:0] C_LU   = 9'b00111_010_0;
  localparam logic [8:0] C_BR   = 9'b11111_110_0;
  localparam logic [8:0] C_BRR  = 9'b11111_110_1;

  int vecs = 0;
  int errs = 0;
  int exp_stall = 0;

  task automatic idle();
    ifid_rs = 5'd0; ifid_rt = 5'd0; ifid_uses_rt = 1'b0;
    idex_mem_rd = 1'b0; idex_rt = 5'd0; ex_branch_taken = 1'b0;
    exmem_mem_rd = 1'b0; exmem_mem_wr = 1'b0; dmem_ready = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle();
    exmem_mem_rd = 1'b1; ex_branch_taken = 1'b1;
    #2;
    vecs++; if (ctl !== C_ZERO) begin errs++; $display("FAIL reset_ctl got %b exp %b", ctl, C_ZERO); end
    vecs++; if (mem_err !== 1'b0 || stall_cycles !== 16'd0) begin errs++; $display("FAIL reset_regs got err=%b stall=%0d exp 0/0", mem_err, stall_cycles); end
    tick();
    vecs++; if (stall_cycles !== 16'd0) begin errs++; $display("FAIL reset_hold_stall got %0d exp 0", stall_cycles); end
    reset = 1'b0;
    idle();
    #1;
    vecs++; if (ctl !== C_DEF) begin errs++; $display("FAIL post_reset_ctl got %b exp %b", ctl, C_DEF); end
    tick();
  endtask

  task automatic test_load_use();
    idex_mem_rd = 1'b1; idex_rt = 5'd8; ifid_rs = 5'd8;
    #1;
    vecs++; if (ctl !== C_LU) begin errs++; $display("FAIL lu_rs got %b exp %b", ctl, C_LU); end
    tick(); exp_stall++;
    idle(); #1;
    vecs++; if (ctl !== C_DEF || stall_cycles !== 16'(exp_stall)) begin errs++; $display("FAIL lu_after got %b/%0d exp %b/%0d", ctl, stall_cycles, C_DEF, exp_stall); end
    idex_mem_rd = 1'b1; idex_rt = 5'd5; ifid_rt = 5'd5; ifid_uses_rt = 1'b1; ifid_rs = 5'd3;
    #1;
    vecs++; if (ctl !== C_LU) begin errs++; $display("FAIL lu_rt got %b exp %b", ctl, C_LU); end
    tick(); exp_stall++;
    ifid_uses_rt = 1'b0; #1;
    vecs++; if (ctl !== C_DEF) begin errs++; $display("FAIL lu_rt_unused got %b exp %b", ctl, C_DEF); end
    tick();
    idex_rt = 5'd0; ifid_rs = 5'd0; ifid_rt = 5'd0; ifid_uses_rt = 1'b1; #1;
    vecs++; if (ctl !== C_DEF) begin errs++; $display("FAIL lu_r0 got %b exp %b", ctl, C_DEF); end
    tick();
    vecs++; if (stall_cycles !== 16'(exp_stall)) begin errs++; $display("FAIL lu_count got %0d exp %0d", stall_cycles, exp_stall); end
    idle();
  endtask

  task automatic test_branch();
    idex_mem_rd = 1'b1; idex_rt = 5'd9; ifid_rs = 5'd9; ex_branch_taken = 1'b1;
    #1;
    vecs++; if (ctl !== C_BR) begin errs++; $display("FAIL br_lu got %b exp %b", ctl, C_BR); end
    tick();
    idle(); ex_branch_taken = 1'b1; #1;
    vecs++; if (ctl !== C_BR) begin errs++; $display("FAIL br_only got %b exp %b", ctl, C_BR); end
    tick();
    idle(); #1;
    vecs++; if (stall_cycles !== 16'(exp_stall)) begin errs++; $display("FAIL br_count got %0d exp %0d", stall_cycles, exp_stall); end
  endtask

  task automatic test_mem_wait();
    // Single-cycle memory: no stall.
    exmem_mem_rd = 1'b1; dmem_ready = 1'b1; #1;
    vecs++; if (ctl !== C_DEFR) begin errs++; $display("FAIL mem_1cyc got %b exp %b", ctl, C_DEFR); end
    tick();
    // Three non-ready cycles, then ready.
    dmem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      vecs++; if (ctl !== C_FRZ) begin errs++; $display("FAIL mem_frz%0d got %b exp %b", i, ctl, C_FRZ); end
      tick(); exp_stall++;
    end
    dmem_ready = 1'b1; #1;
    vecs++; if (ctl !== C_DEFR) begin errs++; $display("FAIL mem_release got %b exp %b", ctl, C_DEFR); end
    tick();
    idle(); #1;
    vecs++; if (ctl !== C_DEF || stall_cycles !== 16'(exp_stall)) begin errs++; $display("FAIL mem_after got %b/%0d exp %b/%0d", ctl, stall_cycles, C_DEF, exp_stall); end
    // Release coinciding with a taken branch.
    exmem_mem_wr = 1'b1; tick(); exp_stall++;
    dmem_ready = 1'b1; ex_branch_taken = 1'b1; idex_mem_rd = 1'b1; idex_rt = 5'd4; ifid_rs = 5'd4; #1;
    vecs++; if (ctl !== C_BRR) begin errs++; $display("FAIL mem_release_br got %b exp %b", ctl, C_BRR); end
    tick();
    idle();
  endtask

  task automatic test_timeout();
    exmem_mem_wr = 1'b1;
    for (int i = 0; i <= 16; i++) begin
      #1;
      if (i == 16) begin
        vecs++; if (ctl !== C_FRZ || mem_err !== 1'b0) begin errs++; $display("FAIL to_last_wait got %b/%b exp %b/0", ctl, mem_err, C_FRZ); end
      end
      tick(); exp_stall++;
    end
    vecs++; if (ctl !== C_ZERO || mem_err !== 1'b1) begin errs++; $display("FAIL to_error got %b/%b exp %b/1", ctl, mem_err, C_ZERO); end
    dmem_ready = 1'b1;
    tick(); tick(); exp_stall += 2;
    vecs++; if (ctl !== C_ZERO || mem_err !== 1'b1 || stall_cycles !== 16'(exp_stall)) begin errs++; $display("FAIL to_sticky got %b/%b/%0d exp %b/1/%0d", ctl, mem_err, stall_cycles, C_ZERO, exp_stall); end
    // Leave ERROR via reset, then let ready arrive on the last allowed cycle.
    reset = 1'b1; idle(); tick(); reset = 1'b0; exp_stall = 0; #1;
    exmem_mem_wr = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick(); exp_stall++;
    end
    dmem_ready = 1'b1; #1;
    vecs++; if (ctl !== C_DEFR) begin errs++; $display("FAIL to_late_ready got %b exp %b", ctl, C_DEFR); end
    tick();
    idle(); #1;
    vecs++; if (ctl !== C_DEF || mem_err !== 1'b0 || stall_cycles !== 16'(exp_stall)) begin errs++; $display("FAIL to_late_after got %b/%b/%0d exp %b/0/%0d", ctl, mem_err, stall_cycles, C_DEF, exp_stall); end
  endtask

  task automatic test_reset_mid_wait();
    exmem_mem_rd = 1'b1;
    tick(); tick(); exp_stall += 2;
    vecs++; if (ctl !== C_FRZ) begin errs++; $display("FAIL mw_wait2 got %b exp %b", ctl, C_FRZ); end
    #2 reset = 1'b1;
    #1;
    vecs++; if (ctl !== C_ZERO || mem_err !== 1'b0 || stall_cycles !== 16'd0) begin errs++; $display("FAIL mw_async got %b/%b/%0d exp %b/0/0", ctl, mem_err, stall_cycles, C_ZERO); end
    exp_stall = 0;
    idle();
    tick();
    reset = 1'b0; #1;
    vecs++; if (ctl !== C_DEF) begin errs++; $display("FAIL mw_release got %b exp %b", ctl, C_DEF); end
    tick();
  endtask

  task automatic test_saturation();
    idex_mem_rd = 1'b1; idex_rt = 5'd7; ifid_rs = 5'd7;
    for (int i = 0; i < 20; i++) begin
      tick(); exp_stall++;
    end
    vecs++; if (s_stall_cycles !== 4'd15 || stall_cycles !== 16'(exp_stall)) begin errs++; $display("FAIL sat_20 got %0d/%0d exp 15/%0d", s_stall_cycles, stall_cycles, exp_stall); end
    tick(); tick(); exp_stall += 2;
    vecs++; if (s_stall_cycles !== 4'd15 || stall_cycles !== 16'(exp_stall)) begin errs++; $display("FAIL sat_hold got %0d/%0d exp 15/%0d", s_stall_cycles, stall_cycles, exp_stall); end
    idle();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch();
    test_mem_wait();
    test_timeout();
    test_reset_mid_wait();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
